// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Brief    : Receives a little-endian program image over a byte stream,
//            writes 32-bit words into instruction memory and holds the CPU
//            in reset until the image is loaded plus a fixed settle delay.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_WIDTH    = 8,
    parameter int RELEASE_DELAY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reload,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Word counter carries one extra bit so a full-capacity image can be
    // counted to completion without the index wrapping.
    localparam int                 c_cnt_w    = ADDR_WIDTH + 1;
    localparam int                 c_dly_w    = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
    localparam logic [c_dly_w-1:0] c_dly_last = c_dly_w'(RELEASE_DELAY - 1);
    localparam logic [16:0]        c_capacity = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_HDR0    = 3'd0,
        S_HDR1    = 3'd1,
        S_DATA    = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_byte_cnt;
    logic [c_cnt_w-1:0]   r_word_idx;
    logic [15:0]          r_word_count;
    logic [c_dly_w-1:0]   r_dly_cnt;
    logic [23:0]          r_lanes;
    logic                 r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]          r_imem_wdata;

    logic                 w_hs;
    logic [15:0]          w_n;
    logic [c_cnt_w-1:0]   w_word_next;
    logic                 w_word_last;

    // Next-state decode and status outputs, all derived from the current state.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        cpu_reset    = 1'b1;
        w_n          = {in_data, r_word_count[7:0]};
        w_word_next  = r_word_idx + 1'b1;
        w_word_last  = (w_word_next == c_cnt_w'(r_word_count));

        case (r_state)
            S_HDR0:    in_ready = ~reload;
            S_HDR1:    begin in_ready = ~reload; busy = 1'b1; end
            S_DATA:    begin in_ready = ~reload; busy = 1'b1; end
            S_RELEASE: busy = 1'b1;
            S_DONE:    begin done = 1'b1; cpu_reset = 1'b0; end
            S_ERROR:   error = 1'b1;
            default:   ;
        endcase

        w_hs = in_valid & in_ready;

        if (reload) begin
            w_state_next = S_HDR0;
        end else begin
            case (r_state)
                S_HDR0: if (w_hs) w_state_next = S_HDR1;
                S_HDR1: begin
                    if (w_hs) begin
                        if (w_n == 16'd0)
                            w_state_next = S_RELEASE;
                        else if ({1'b0, w_n} > c_capacity)
                            w_state_next = S_ERROR;
                        else
                            w_state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_hs && (r_byte_cnt == 2'd3) && w_word_last)
                        w_state_next = S_RELEASE;
                end
                S_RELEASE: if (r_dly_cnt == c_dly_last) w_state_next = S_DONE;
                default:   ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_HDR0;
        else        r_state <= w_state_next;
    end

    // Header capture, word assembly, memory write port and release delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_cnt   <= '0;
            r_word_idx   <= '0;
            r_word_count <= '0;
            r_dly_cnt    <= '0;
            r_lanes      <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_imem_we <= 1'b0;
            if (reload) begin
                r_byte_cnt   <= '0;
                r_word_idx   <= '0;
                r_word_count <= '0;
                r_dly_cnt    <= '0;
            end else begin
                case (r_state)
                    S_HDR0: if (w_hs) r_word_count[7:0] <= in_data;
                    S_HDR1: begin
                        if (w_hs) begin
                            r_word_count[15:8] <= in_data;
                            r_byte_cnt         <= '0;
                            r_word_idx         <= '0;
                            r_dly_cnt          <= '0;
                        end
                    end
                    S_DATA: begin
                        if (w_hs) begin
                            case (r_byte_cnt)
                                2'd0: r_lanes[7:0]   <= in_data;
                                2'd1: r_lanes[15:8]  <= in_data;
                                2'd2: r_lanes[23:16] <= in_data;
                                default: begin
                                    r_imem_we    <= 1'b1;
                                    r_imem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                                    r_imem_wdata <= {in_data, r_lanes};
                                    r_word_idx   <= w_word_next;
                                end
                            endcase
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                    S_RELEASE: r_dly_cnt <= r_dly_cnt + 1'b1;
                    default:   ;
                endcase
            end
        end
    end

    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Brief    : Randomized self-checking bench for imem_boot_loader with an
//            image-level reference model and a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int ADDR_WIDTH    = 8;
    localparam int RELEASE_DELAY = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  reload;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_reset;
    logic                  busy;
    logic                  done;
    logic                  error;

    imem_boot_loader #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .RELEASE_DELAY (RELEASE_DELAY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reload     (reload),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Rising-edge count; the value seen at a falling edge names the last edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int          addr;
        logic [31:0] data;
        int          at;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every observed write must match the next expected one.
    always @(negedge clk) begin
        if (imem_we !== 1'b0) begin
            check_eq("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("write_addr",  32'(imem_addr), 32'(e.addr));
                check_eq("write_data",  imem_wdata, e.data);
                check_eq("write_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap, output int hs);
        int gap;
        int tries;
        gap   = $urandom_range(max_gap, 0);
        tries = 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        while (in_ready !== 1'b1 && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (tries >= 50) check_eq("handshake_timeout", 32'(in_ready), 32'd1);
        hs = cyc + 1;
    endtask

    // Reference model: image bytes 0..1 are N, then word w occupies bytes
    // 2+4w .. 5+4w; each complete word appears one edge after its last byte.
    task automatic send_image(input byte_q_t img, input int max_gap, output int last_hs);
        int  n;
        int  hs;
        wr_t w;
        n       = (img.size() >= 2) ? int'({img[1], img[0]}) : 0;
        last_hs = cyc;
        for (int k = 0; k < img.size(); k++) begin
            send_byte(img[k], max_gap, hs);
            if (k >= 2 && ((k - 2) % 4) == 3 && ((k - 2) / 4) < n && n <= (1 << ADDR_WIDTH)) begin
                w.addr = (k - 2) / 4;
                w.data = {img[k], img[k-1], img[k-2], img[k-3]};
                w.at   = hs;
                exp_q.push_back(w);
            end
            last_hs = hs;
        end
    endtask

    task automatic wait_done(input int last_hs, input string tag);
        int early;
        int guard;
        early = 0;
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
            if (cyc < last_hs + RELEASE_DELAY && (done !== 1'b0 || cpu_reset !== 1'b1)) early++;
        end while (cyc < last_hs + RELEASE_DELAY && guard < 3000);
        check_eq({tag, "_early_release"}, 32'(early), 32'd0);
        check_eq({tag, "_done"},          32'(done), 32'd1);
        check_eq({tag, "_cpu_reset"},     32'(cpu_reset), 32'd0);
        check_eq({tag, "_in_ready"},      32'(in_ready), 32'd0);
        check_eq({tag, "_writes_left"},   32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reload(input string tag);
        @(negedge clk);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        #1;
        check_eq({tag, "_ready_in_reload"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq({tag, "_done_clr"},  32'(done), 32'd0);
        check_eq({tag, "_error_clr"}, 32'(error), 32'd0);
        check_eq({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check_eq({tag, "_ready"},     32'(in_ready), 32'd1);
        check_eq({tag, "_idle"},      32'(busy), 32'd0);
    endtask

    initial begin
        byte_q_t img;
        int      hs;
        int      n;
        int      stuck;

        reset    = 1'b0;
        reload   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("rst_we",        32'(imem_we), 32'd0);
        check_eq("rst_addr",      32'(imem_addr), 32'd0);
        check_eq("rst_wdata",     imem_wdata, 32'd0);
        check_eq("rst_done",      32'(done), 32'd0);
        check_eq("rst_error",     32'(error), 32'd0);
        check_eq("rst_busy",      32'(busy), 32'd0);
        check_eq("rst_ready",     32'(in_ready), 32'd1);
        reset = 1'b1;

        // Two-word program streamed back to back.
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
        send_image(img, 0, hs);
        wait_done(hs, "two_words");

        // Empty image goes straight to the release delay.
        do_reload("r1");
        img = '{8'h00, 8'h00};
        send_image(img, 0, hs);
        wait_done(hs, "empty");

        // Oversized image is rejected and parks in error.
        do_reload("r2");
        img = '{8'h01, 8'h01};
        send_image(img, 0, hs);
        @(negedge clk);
        #1;
        check_eq("err_error",     32'(error), 32'd1);
        check_eq("err_ready",     32'(in_ready), 32'd0);
        check_eq("err_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("err_busy",      32'(busy), 32'd0);
        stuck = 0;
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            #1;
            if (in_ready !== 1'b0 || error !== 1'b1) stuck++;
        end
        check_eq("err_sticky", 32'(stuck), 32'd0);
        do_reload("r3");

        // Single word with random stalls inside the word.
        img = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
        send_image(img, 3, hs);
        wait_done(hs, "one_word_gaps");

        // Reload mid-word discards the partial word.
        do_reload("r4");
        img = '{8'h02, 8'h00, 8'h13, 8'h05};
        send_image(img, 1, hs);
        do_reload("r5");
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_image(img, 1, hs);
        wait_done(hs, "after_abort");

        // Random small images.
        for (int r = 0; r < 4; r++) begin
            do_reload("rr");
            n   = $urandom_range(6, 1);
            img = '{};
            img.push_back(8'(n));
            img.push_back(8'(n >> 8));
            for (int k = 0; k < 4 * n; k++) img.push_back(8'($urandom));
            send_image(img, 2, hs);
            wait_done(hs, "random");
        end

        // Full-capacity image: last address is all ones.
        do_reload("r6");
        n   = 1 << ADDR_WIDTH;
        img = '{};
        img.push_back(8'(n));
        img.push_back(8'(n >> 8));
        for (int k = 0; k < 4 * n; k++) img.push_back(8'($urandom));
        send_image(img, 1, hs);
        wait_done(hs, "full");

        // Asynchronous reset while a write pulse is on the port.
        do_reload("r7");
        img = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_image(img, 0, hs);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_eq("we_before_async_reset", 32'(imem_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        check_eq("arst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("arst_we",        32'(imem_we), 32'd0);
        check_eq("arst_addr",      32'(imem_addr), 32'd0);
        check_eq("arst_wdata",     imem_wdata, 32'd0);
        check_eq("arst_busy",      32'(busy), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b1;
        img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_image(img, 1, hs);
        wait_done(hs, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle RISC-V processor.
- Receives a program image as a byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words.
- Writes those words into the processor's instruction memory through its write port.
- Holds the processor in reset until the image is fully loaded, then releases it after a fixed delay.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity = 2**ADDR_WIDTH words.
- RELEASE_DELAY, 4, clk cycles between the last word write and cpu_reset deassertion (min 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- reload  input  1  synchronous pulse; aborts or restarts a load.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  byte-stream ready (combinational from state and reload).
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  instruction word.
- cpu_reset  output  1  active-high reset to the processor; 1 while loading.
- busy  output  1  high in HDR1, DATA and RELEASE.
- done  output  1  high in DONE.
- error  output  1  high in ERROR.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=HDR0.
  - cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0.
  - Byte counter, word counter, word_count register and delay counter all 0.
- Handshake:
  - A byte is accepted on a rising edge with in_valid & in_ready.
  - in_ready = (state in {HDR0, HDR1, DATA}) & ~reload.
  - in_data is ignored when no handshake occurs.
- Image format:
  - 2-byte little-endian word count N.
  - Then 4*N bytes: each word is byte0 in bits [7:0] up to byte3 in bits [31:24].
- FSM states: HDR0, HDR1, DATA, RELEASE, DONE, ERROR.
- HDR0: accepted byte -> N[7:0], go to HDR1.
- HDR1: accepted byte -> N[15:8], then:
  - N==0 -> RELEASE.
  - N > 2**ADDR_WIDTH -> ERROR.
  - otherwise -> DATA.
- DATA:
  - 2-bit byte counter selects the lane.
  - On the 4th byte of a word, in the next cycle: imem_we=1 for exactly one cycle, imem_addr = word index, imem_wdata = the assembled word.
  - Write latency is 1 cycle after the 4th handshake.
  - in_ready stays 1 during the write pulse, so back-to-back bytes with no stalls are sustained.
  - Word index increments after each write.
  - After the N-th word's 4th byte -> RELEASE. The imem_we pulse for that word occurs in the first RELEASE cycle.
- RELEASE:
  - Counts RELEASE_DELAY cycles, then -> DONE.
  - cpu_reset remains 1 throughout.
- DONE:
  - cpu_reset=0, done=1, in_ready=0.
  - Stays until reload or reset.
- ERROR:
  - cpu_reset=1, error=1, in_ready=0, no writes.
  - Stays until reload or reset.
- reload=1 (any state):
  - Next state HDR0.
  - cpu_reset=1 the next cycle; done=0, error=0.
  - Counters cleared; any partial word discarded.
  - A pending imem_we pulse already registered still completes.
  - reload has priority over a same-cycle byte (in_ready is forced to 0).
- Edge cases:
  - N == 2**ADDR_WIDTH is legal; the last address is all ones and the word index does not wrap before completion.
  - in_valid deasserting mid-word stalls the byte counter; there is no timeout.
  - imem_addr and imem_wdata hold their last value when imem_we=0.
- Asynchronous reset mid-load: immediate return to the reset values, including cpu_reset=1 and imem_we=0.

Test Plan:
- Reset, then stream 02 00 13 05 A0 00 93 05 50 00 with in_valid held high -> imem_we pulses at addr 0 with data 0x00A00513 and at addr 1 with data 0x00500593. cpu_reset falls 4 cycles after the second pulse; done=1.
- Header 00 00 -> no imem_we; RELEASE for 4 cycles, then done=1, cpu_reset=0.
- Header 01 01 (N=257) with ADDR_WIDTH=8 -> error=1, in_ready=0, cpu_reset stays 1, no writes. Then a reload pulse -> error=0, in_ready=1, state HDR0.
- N=1 with random in_valid gaps between 13 05 A0 00 -> a single write of 0x00A00513 at addr 0, 1 cycle after the 4th handshake; no extra writes.
- Assert reload after 2 data bytes of word 1 (N=2), then send a full 1-word image of 0xDEADBEEF -> write at addr 0 with 0xDEADBEEF; the stale partial word is never written.
- Drive reset low mid-DATA -> cpu_reset=1, imem_we=0 immediately; after release, the next byte is treated as header byte 0.
